// File: rtl/mealy_seq_pkg.sv
//==============================================================================
// Module  : mealy_seq_pkg
// Brief   : Shared state type, default pattern and KMP fallback function for
//           the 4-bit Mealy sequence detector.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package mealy_seq_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

    // Next state from state Sk on bit b: longest pattern prefix (max 3 bits)
    // that is a suffix of the k matched bits followed by b.
    function automatic state_t fail_next(input logic [3:0] pattern, input int k, input logic b);
        logic [3:0] s;
        logic [1:0] idx;
        logic       ok;
        int         best;
        s    = '0;
        best = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < k) begin
                s[2'(i)] = pattern[2'(3 - i)];
            end else if (i == k) begin
                s[2'(i)] = b;
            end
        end
        for (int l = 1; l <= 3; l++) begin
            if (l <= k + 1) begin
                ok = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    if (j < l) begin
                        idx = 2'(k + 1 - l + j);
                        if (pattern[2'(3 - j)] != s[idx]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = l;
                end
            end
        end
        return state_t'(best[1:0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shift4.sv
//==============================================================================
// Module  : seq_shift4
// Brief   : 4-bit history shift register, newest bit in seq[0], async clear.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_shift4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic [3:0] seq
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq <= 4'b0000;
        end else begin
            seq <= {seq[2:0], in};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mealy_seq_detector.sv
//==============================================================================
// Module  : mealy_seq_detector
// Brief   : Overlapping 4-bit serial pattern detector (Mealy FSM) with bit
//           history. Optional macro MEALY_HIT_COUNT_EN adds an 8-bit hit counter.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mealy_seq_detector
    import mealy_seq_pkg::*;
#(
    parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
    parameter int         OVERLAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       out,
    output logic [3:0] seq
`ifdef MEALY_HIT_COUNT_EN
    ,
    output logic [7:0] hit_cnt
`endif
);

    localparam logic [1:0] ST_S0 = S0;
    localparam logic [1:0] ST_S3 = S3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       hit;
    logic [1:0] next_tbl [8];

    // Transition table indexed by {state, in}; folds to constants at elaboration.
    for (genvar k = 0; k < 4; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            assign next_tbl[k*2+b] = fail_next(PATTERN, k, 1'(b));
        end
    end

    always_comb begin
        hit       = 1'b0;
        state_nxt = next_tbl[{state, in}];
        if ((state == ST_S3) && (in == PATTERN[0])) begin
            hit = 1'b1;
            if (OVERLAP == 0) begin
                state_nxt = ST_S0;
            end
        end
    end

    // Reset must silence the flag even while in would complete a match.
    assign out = hit & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_S0;
        end else begin
            state <= state_nxt;
        end
    end

    seq_shift4 u_hist (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .seq (seq)
    );

`ifdef MEALY_HIT_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt <= 8'd0;
        end else if (out) begin
            hit_cnt <= hit_cnt + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mealy_seq_detector.sv
//==============================================================================
// Module  : tb_mealy_seq_detector
// Brief   : Self-checking bench: directed streams plus random bits against a
//           last-four-bits reference model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mealy_seq_detector;

    localparam logic [3:0] PAT = 4'b1101;

    logic       clk;
    logic       rst;
    logic       in;
    logic       out;
    logic [3:0] seq;
`ifdef MEALY_HIT_COUNT_EN
    logic [7:0] hit_cnt;
`endif

    int tests;
    int fails;
    int pulses;

    bit         hist[$];
    logic [3:0] mseq;
    logic [7:0] mcnt;

    mealy_seq_detector dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .out     (out),
        .seq     (seq)
`ifdef MEALY_HIT_COUNT_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hit whenever the three previous bits since reset plus b spell the pattern.
    function automatic logic exp_out(input bit b);
        if (hist.size() < 3) return 1'b0;
        return ({hist[0], hist[1], hist[2], b} == PAT);
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_out_now", {7'd0, out}, 8'd0);
        check("rst_seq_now", {4'd0, seq}, 8'd0);
        for (int i = 0; i < 10; i++) begin
            in = ~in;
            #5;
            check("rst_hold_out", {7'd0, out}, 8'd0);
            check("rst_hold_seq", {4'd0, seq}, 8'd0);
        end
`ifdef MEALY_HIT_COUNT_EN
        check("rst_cnt", hit_cnt, 8'd0);
`endif
        hist.delete();
        mseq   = 4'd0;
        mcnt   = 8'd0;
        pulses = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    task automatic step(input bit b);
        logic e;
        in = b;
        e  = exp_out(b);
        @(negedge clk);
        #2;
        check("out", {7'd0, out}, {7'd0, e});
        if (out === 1'b1) pulses++;
        @(posedge clk);
        hist.push_back(b);
        if (hist.size() > 3) void'(hist.pop_front());
        mseq = {mseq[2:0], b};
        if (e) mcnt = mcnt + 8'd1;
        #1;
        check("seq", {4'd0, seq}, {4'd0, mseq});
`ifdef MEALY_HIT_COUNT_EN
        check("hit_cnt", hit_cnt, mcnt);
`endif
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i]);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        pulses = 0;
        mseq   = 4'd0;
        mcnt   = 8'd0;
        in     = 1'b0;
        rst    = 1'b1;

        apply_reset();
        feed(32'b1101, 4);
        check("basic_pulses", 8'(pulses), 8'd1);
        check("basic_seq", {4'd0, seq}, 8'b1101);

        apply_reset();
        feed(32'b11010110100110, 14);
        check("full_pulses", 8'(pulses), 8'd2);
        check("full_seq", {4'd0, seq}, 8'b0110);
`ifdef MEALY_HIT_COUNT_EN
        check("full_hit_cnt", hit_cnt, 8'd2);
`endif

        apply_reset();
        feed(32'b1101101, 7);
        check("overlap_pulses", 8'(pulses), 8'd2);

        apply_reset();
        feed(32'b11101, 5);
        check("near1_pulses", 8'(pulses), 8'd1);

        apply_reset();
        feed(32'b11001101, 8);
        check("near2_pulses", 8'(pulses), 8'd1);

        // Partial match 110, then reset with in=1 poised to complete it.
        apply_reset();
        feed(32'b110, 3);
        in = 1'b1;
        #2;
        check("pre_rst_out", {7'd0, out}, 8'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_out", {7'd0, out}, 8'd0);
        check("mid_rst_seq", {4'd0, seq}, 8'd0);
        apply_reset();
        step(1'b1);
        check("post_rst_pulses", 8'(pulses), 8'd0);

        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) apply_reset();
            step(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
